gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and code width in bits (legal range 2..16).
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  count-step request.
REQ-005 up  input  1  direction: 1 = increment, 0 = decrement; sampled on each step.
REQ-006 load  input  1  synchronous load request.
REQ-007 load_bin  input  WIDTH  binary value for load.
REQ-008 out_ready  input  1  downstream Gray-to-binary stage accepts the current code.
REQ-009 gray  output  WIDTH  registered Gray code of the internal binary count.
REQ-010 out_valid  output  1  gray holds a code not yet accepted.
REQ-011 wrap  output  1  one-cycle pulse on count wrap-around.

Function
REQ-012 Internal state: binary count cnt (WIDTH bits); gray SHALL equal cnt ^ (cnt >> 1), registered, never combinational from inputs.
REQ-013 Accept event: out_valid=1 and out_ready=1 in the same cycle.
REQ-014 Step condition: en=1, load=0, and (out_valid=0 or out_ready=1); only a step or load changes cnt.
REQ-015 On step, cnt becomes cnt+1 (up=1) or cnt-1 (up=0) modulo 2^WIDTH; gray updates on the same edge; latency from step cycle to new gray is 1 clock.
REQ-016 A step SHALL set out_valid=1 on the next edge, including a step in the same cycle as an accept.
REQ-017 An accept without a step or load SHALL clear out_valid on the next edge.
REQ-018 When out_valid=1 and out_ready=0, gray and cnt SHALL hold regardless of en (no code is lost).
REQ-019 load=1 SHALL have priority over en: cnt becomes load_bin, out_valid=1 next edge, backpressure ignored; any unaccepted code is overwritten.
REQ-020 wrap SHALL be 1 for exactly the cycle after a step from all-ones to zero (up) or zero to all-ones (down); it SHALL be 0 after a load, a hold, or reset.
REQ-021 Consecutive accepted codes from steps SHALL differ in exactly one bit.

Reset
REQ-022 While rst=1 on an edge: cnt=0, gray=0, out_valid=0, wrap=0 (and parity=0 when enabled); rst has priority over load and en.
REQ-023 Reset mid-operation SHALL discard any pending code; the first step after reset SHALL produce gray=0...01 (up) or 10...0 (down).

Configuration
REQ-024 Macro GRAY_COUNTER_PARITY_EN: when defined, an extra output parity (1 bit) SHALL be present, registered with gray, equal to XOR of all bits of cnt (even parity of the binary value).
REQ-025 Without GRAY_COUNTER_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Shared package gray_pkg SHALL hold the default WIDTH constant and the direction constants DIR_UP=1, DIR_DOWN=0.
REQ-027 One sub-module bin2gray (combinational, WIDTH-parameterised, binary in, Gray out) SHALL be instantiated for the gray register input; all sequential logic stays in gray_counter.

Verification (WIDTH=4)
REQ-028 rst=1 two cycles, then release -> gray=0000, out_valid=0, wrap=0.
REQ-029 en=1, up=1, out_ready=1 for 16 steps -> gray sequence 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; wrap=1 only on the final 0000.
REQ-030 From reset, en=1, up=0, out_ready=1, one step -> gray=1000, wrap=1.
REQ-031 Step to gray=0001, then out_ready=0 with en=1 for 5 cycles -> gray=0001, out_valid=1 held; out_ready=1 -> next cycle gray=0011.
REQ-032 load=1, load_bin=1010 with out_ready=0 and a pending code -> next cycle gray=1111, out_valid=1, wrap=0; with GRAY_COUNTER_PARITY_EN, parity=0.
REQ-033 rst=1 asserted mid-count at gray=0110 with en=1, load=1 -> next cycle gray=0000, out_valid=0; the next up step gives 0001.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code counter block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gray_pkg;

    // Default counter / code width in bits.
    localparam int GRAY_WIDTH_DEFAULT = 4;

    // Values carried on the direction input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : gray_pkg

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter, WIDTH bits.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input.
module bin2gray #(
    parameter int WIDTH = gray_pkg::GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    // Adjacent binary values map to codes that differ in a single bit.
    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule : bin2gray

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray-code output, load, and valid/ready handshake.
// Latency: 1 cycle from step/load to new gray; wrap pulses for the cycle after a wrapping step.
// Backpressure: out_valid=1 with out_ready=0 freezes the count (en ignored); load overrides it.
// Optional: define GRAY_COUNTER_PARITY_EN to add a registered even-parity output of the count.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gray,
    output logic             out_valid,
`ifdef GRAY_COUNTER_PARITY_EN
    output logic             parity,
`endif
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             out_valid_q, out_valid_d;
    logic             wrap_q, wrap_d;
    logic             step;

    // A step may proceed only when no code is pending or the pending one is taken now.
    assign step = en & ~load & (~out_valid_q | out_ready);

    // Next count, valid and wrap; load wins over a step and ignores backpressure.
    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q & ~out_ready;
        wrap_d      = 1'b0;
        if (load) begin
            cnt_d       = load_bin;
            out_valid_d = 1'b1;
        end else if (step) begin
            out_valid_d = 1'b1;
            if (up == DIR_UP) begin
                cnt_d  = cnt_q + WIDTH'(1);
                wrap_d = &cnt_q;
            end else begin
                cnt_d  = cnt_q - WIDTH'(1);
                wrap_d = (cnt_q == '0);
            end
        end
    end

    // Gray register input is converted from the next count so code and count move together.
    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin_i  (cnt_d),
        .gray_o (gray_d)
    );

    // State registers; reset clears everything and discards any pending code.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            gray_q      <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            gray_q      <= gray_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
        end
    end

`ifdef GRAY_COUNTER_PARITY_EN
    logic parity_q;

    // Even parity of the binary count, registered alongside the Gray code.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^cnt_d;
        end
    end

    assign parity = parity_q;
`endif

    assign gray      = gray_q;
    assign out_valid = out_valid_q;
    assign wrap      = wrap_q;

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter at WIDTH=4.
// Latency: inputs change #1 after a rising edge, outputs sampled #1 after the next.
// Backpressure: exercised by holding out_ready low with en high.
module tb_gray_counter;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_bin;
    logic         out_ready;
    logic [W-1:0] gray;
    logic         out_valid;
    logic         wrap;
`ifdef GRAY_COUNTER_PARITY_EN
    logic         parity;
`endif

    int n_cmp = 0;
    int n_err = 0;

    gray_counter #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_bin  (load_bin),
        .out_ready (out_ready),
        .gray      (gray),
        .out_valid (out_valid),
`ifdef GRAY_COUNTER_PARITY_EN
        .parity    (parity),
`endif
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hand-computed up-count Gray sequence starting from 0001.
    logic [W-1:0] up_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                  4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                  4'b1011, 4'b1001, 4'b1000, 4'b0000};

    initial begin
        logic [W-1:0] prev;
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0; out_ready = 1'b0;

        // Reset for two cycles then release.
        tick(); tick();
        rst = 1'b0;
        check("rst_gray", 32'(gray), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        tick();
        check("idle_gray", 32'(gray), 32'h0);
        check("idle_valid", 32'(out_valid), 32'h0);

        // Sixteen up steps with the consumer always ready.
        en = 1'b1; up = 1'b1; out_ready = 1'b1;
        prev = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("up_gray_%0d", i), 32'(gray), 32'(up_seq[i]));
            check($sformatf("up_wrap_%0d", i), 32'(wrap), (i == 15) ? 32'h1 : 32'h0);
            check($sformatf("up_valid_%0d", i), 32'(out_valid), 32'h1);
            check($sformatf("up_onebit_%0d", i), 32'($countones(prev ^ gray)), 32'h1);
            prev = gray;
        end

        // Accept with no step clears valid; wrap drops after one cycle.
        en = 1'b0;
        tick();
        check("acc_valid", 32'(out_valid), 32'h0);
        check("acc_wrap", 32'(wrap), 32'h0);
        check("acc_gray", 32'(gray), 32'h0);

        // Down step from zero wraps to all-ones.
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; up = 1'b0;
        tick();
        check("dn_gray", 32'(gray), 32'b1000);
        check("dn_wrap", 32'(wrap), 32'h1);
        check("dn_valid", 32'(out_valid), 32'h1);
        tick();
        check("dn2_gray", 32'(gray), 32'b1001);
        check("dn2_wrap", 32'(wrap), 32'h0);
        en = 1'b0;
        tick();
        check("dn_hold_gray", 32'(gray), 32'b1001);

        // Backpressure holds the code while en stays high.
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; up = 1'b1; out_ready = 1'b1;
        tick();
        check("bp_first", 32'(gray), 32'b0001);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_gray_%0d", i), 32'(gray), 32'b0001);
            check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release", 32'(gray), 32'b0011);

        // Load overrides a pending code under backpressure.
        out_ready = 1'b0;
        tick();
        check("ld_pend_gray", 32'(gray), 32'b0011);
        load = 1'b1; load_bin = 4'b1010;
        tick();
        check("ld_gray", 32'(gray), 32'b1111);
        check("ld_valid", 32'(out_valid), 32'h1);
        check("ld_wrap", 32'(wrap), 32'h0);
`ifdef GRAY_COUNTER_PARITY_EN
        check("ld_parity", 32'(parity), 32'h0);
`endif
        load_bin = 4'b0111;
        tick();
        check("ld2_gray", 32'(gray), 32'b0100);
`ifdef GRAY_COUNTER_PARITY_EN
        check("ld2_parity", 32'(parity), 32'h1);
`endif

        // Load all-ones then step up: wrap pulses; a load after it clears wrap.
        load_bin = 4'b1111; out_ready = 1'b1;
        tick();
        check("ldf_gray", 32'(gray), 32'b1000);
        check("ldf_wrap", 32'(wrap), 32'h0);
        load = 1'b0;
        tick();
        check("ldf_step_gray", 32'(gray), 32'b0000);
        check("ldf_step_wrap", 32'(wrap), 32'h1);

        // Reach 0110 then reset while en and load are both requested.
        load = 1'b1; load_bin = 4'b0011;
        tick();
        check("pre_gray", 32'(gray), 32'b0010);
        load = 1'b0;
        tick();
        check("mid_gray", 32'(gray), 32'b0110);
        rst = 1'b1; load = 1'b1; load_bin = 4'b1111;
        tick();
        check("mrst_gray", 32'(gray), 32'h0);
        check("mrst_valid", 32'(out_valid), 32'h0);
        check("mrst_wrap", 32'(wrap), 32'h0);
        rst = 1'b0; load = 1'b0; up = 1'b1;
        tick();
        check("post_gray", 32'(gray), 32'b0001);
        check("post_valid", 32'(out_valid), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gray_counter
